write_packer: RTL and testbench

Width-up packer that sits directly upstream of the read/write-enable FIFO's write port. It collects RATIO narrow beats of INPUT_WIDTH bits from a producer and writes each assembled INPUT_WIDTH×RATIO word into the FIFO in one write. A flush request emits a partial word with a lane mask. Backpressure from the FIFO's `full` flag propagates back to the producer through the packer's own `full` flag.

---
 rtl/write_packer_if.sv | 25 ++
 rtl/write_packer.sv | 94 +++++++++
 tb/tb_write_packer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/write_packer_if.sv
// Producer-side and FIFO-side signals of the write packer, bundled for connection.
interface write_packer_if #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned RATIO       = 4
);
    logic                           write_enable;
    logic [INPUT_WIDTH-1:0]         write_data;
    logic                           flush;
    logic                           full;
    logic                           packed_write_enable;
    logic [INPUT_WIDTH*RATIO-1:0]   packed_write_data;
    logic [RATIO-1:0]               packed_write_mask;
    logic                           packed_full;
    logic                           pending;

    modport master (
        output write_enable, write_data, flush, packed_full,
        input  full, packed_write_enable, packed_write_data, packed_write_mask, pending
    );

    modport slave (
        input  write_enable, write_data, flush, packed_full,
        output full, packed_write_enable, packed_write_data, packed_write_mask, pending
    );
endinterface

// File: rtl/write_packer.sv
// Width-up packer: gathers RATIO narrow beats into one FIFO write, with masked partial
// words on flush and FIFO backpressure reflected on the producer-side full flag.
module write_packer #(
    parameter int unsigned INPUT_WIDTH = 8,
    parameter int unsigned RATIO       = 4
) (
    input logic           clock,
    input logic           reset,
    write_packer_if.slave bus
);
    localparam int unsigned CntW     = $clog2(RATIO);
    localparam int unsigned OutW     = INPUT_WIDTH * RATIO;
    localparam logic [CntW-1:0] LastLane = CntW'(RATIO - 1);

    logic [RATIO-2:0][INPUT_WIDTH-1:0] lanes_q, lanes_d;
    logic [CntW-1:0]                   lane_count_q, lane_count_d;
    logic                              out_valid_q, out_valid_d;
    logic [OutW-1:0]                   out_data_q, out_data_d;
    logic [RATIO-1:0]                  out_mask_q, out_mask_d;

    logic            at_last;
    logic            free;
    logic            drain;
    logic            accept;
    logic            complete;
    logic [CntW:0]   fill;

    assign at_last  = (lane_count_q == LastLane);
    assign free     = !out_valid_q || !bus.packed_full;
    assign drain    = out_valid_q && !bus.packed_full;
    assign bus.full = !free && at_last;
    assign accept   = bus.write_enable && !bus.full;
    // A flush only completes a word if something is actually held or arriving.
    assign complete = free && ((accept && at_last) ||
                               (bus.flush && ((lane_count_q != '0) || accept)));
    assign fill     = {1'b0, lane_count_q} + {{CntW{1'b0}}, accept};

    always_comb begin
        lanes_d      = lanes_q;
        lane_count_d = lane_count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mask_d   = out_mask_q;
        if (complete) begin
            out_data_d = '0;
            for (int unsigned i = 0; i < RATIO - 1; i++) begin
                if (CntW'(i) < lane_count_q) begin
                    out_data_d[i*INPUT_WIDTH +: INPUT_WIDTH] = lanes_q[i];
                end
            end
            for (int unsigned i = 0; i < RATIO; i++) begin
                if (accept && (CntW'(i) == lane_count_q)) begin
                    out_data_d[i*INPUT_WIDTH +: INPUT_WIDTH] = bus.write_data;
                end
                out_mask_d[i] = ((CntW+1)'(i) < fill);
            end
            out_valid_d  = 1'b1;
            lane_count_d = '0;
        end else begin
            if (accept) begin
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (CntW'(i) == lane_count_q) begin
                        lanes_d[i] = bus.write_data;
                    end
                end
                lane_count_d = lane_count_q + CntW'(1);
            end
            if (drain) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lanes_q      <= '0;
            lane_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_mask_q   <= '0;
        end else begin
            lanes_q      <= lanes_d;
            lane_count_q <= lane_count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_mask_q   <= out_mask_d;
        end
    end

    assign bus.packed_write_enable = drain;
    assign bus.packed_write_data   = out_data_q;
    assign bus.packed_write_mask   = out_mask_q;
    assign bus.pending             = (lane_count_q != '0) || out_valid_q;
endmodule

// File: tb/tb_write_packer.sv
// Randomised and directed bench for write_packer, checked by a queue-based reference model
// and a scoreboard of expected FIFO writes.
module tb_write_packer;
    localparam int unsigned W = 8;
    localparam int unsigned R = 4;

    logic clock;
    logic reset;

    write_packer_if #(.INPUT_WIDTH(W), .RATIO(R)) bus ();

    write_packer #(.INPUT_WIDTH(W), .RATIO(R)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats held so far and the word waiting for the FIFO.
    logic [W-1:0]   held[$];
    logic           m_valid = 1'b0;
    logic [W*R-1:0] m_data  = '0;
    logic [R-1:0]   m_mask  = '0;

    logic [W*R-1:0] sb_data[$];
    logic [R-1:0]   sb_mask[$];

    logic exp_full    = 1'b0;
    logic exp_pwe     = 1'b0;
    logic exp_pending = 1'b0;

    int             wr_count  = 0;
    logic [W*R-1:0] last_data = '0;
    logic [R-1:0]   last_mask = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic model_full(input logic pf);
        return m_valid && pf && (held.size() == R - 1);
    endfunction

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic step(input logic we, input logic [W-1:0] wd, input logic fl,
                        input logic pf, input logic rst);
        logic mfree, mfull, acc, drn;
        @(posedge clock);
        #1;
        reset            = rst;
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.flush        = fl;
        bus.packed_full  = pf;
        mfree = !m_valid || !pf;
        mfull = model_full(pf);
        drn   = m_valid && !pf;
        exp_full    = mfull;
        exp_pwe     = drn;
        exp_pending = (held.size() != 0) || m_valid;
        if (drn) begin
            sb_data.push_back(m_data);
            sb_mask.push_back(m_mask);
        end
        acc = we && !mfull;
        if (rst) begin
            held.delete();
            m_valid = 1'b0;
        end else begin
            if (acc) held.push_back(wd);
            if ((acc && held.size() == R) || (fl && mfree && held.size() != 0)) begin
                m_data = '0;
                foreach (held[i]) m_data[i*W +: W] = held[i];
                m_mask  = R'((1 << held.size()) - 1);
                held.delete();
                m_valid = 1'b1;
            end else if (drn) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    always @(negedge clock) begin
        check("full", 32'(bus.full), 32'(exp_full));
        check("pwe", 32'(bus.packed_write_enable), 32'(exp_pwe));
        check("pending", 32'(bus.pending), 32'(exp_pending));
        if (bus.packed_write_enable) begin
            wr_count++;
            last_data = bus.packed_write_data;
            last_mask = bus.packed_write_mask;
            check("sb_nonempty", 32'(sb_data.size() != 0), 32'(1));
            if (sb_data.size() != 0) begin
                check("wr_data", 32'(bus.packed_write_data), 32'(sb_data.pop_front()));
                check("wr_mask", 32'(bus.packed_write_mask), 32'(sb_mask.pop_front()));
            end
        end
    end

    initial begin
        logic pf, we, fl;
        int   base;
        reset            = 1'b1;
        bus.write_enable = 1'b1;
        bus.write_data   = 8'h5A;
        bus.flush        = 1'b0;
        bus.packed_full  = 1'b0;

        // Reset with write_enable held high
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("rst_full", 32'(bus.full), 32'(0));
        check("rst_pwe", 32'(bus.packed_write_enable), 32'(0));
        check("rst_pwd", 32'(bus.packed_write_data), 32'(0));
        check("rst_pwm", 32'(bus.packed_write_mask), 32'(0));
        check("rst_pending", 32'(bus.pending), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_no_write", 32'(bus.packed_write_enable), 32'(0));

        // Full word
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("word_pwe", 32'(bus.packed_write_enable), 32'(1));
        check("word_data", 32'(bus.packed_write_data), 32'h44332211);
        check("word_mask", 32'(bus.packed_write_mask), 32'hF);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("word_one_write", 32'(bus.packed_write_enable), 32'(0));
        check("word_pending", 32'(bus.pending), 32'(0));

        // Flush alone after two beats
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("flushA_data", 32'(bus.packed_write_data), 32'h0000A2A1);
        check("flushA_mask", 32'(bus.packed_write_mask), 32'h3);
        check("flushA_pwe", 32'(bus.packed_write_enable), 32'(1));

        // Flush together with a beat
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("flushB_data", 32'(bus.packed_write_data), 32'h0000B1B0);
        check("flushB_mask", 32'(bus.packed_write_mask), 32'h3);

        // Flush with nothing held
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("flush_empty_pwe", 32'(bus.packed_write_enable), 32'(0));
        check("flush_empty_pending", 32'(bus.pending), 32'(0));

        // Backpressure
        for (int b = 1; b <= 7; b++) step(1'b1, W'(b), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("bp_full", 32'(bus.full), 32'(1));
        check("bp_no_write", 32'(bus.packed_write_enable), 32'(0));
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        check("bp_full_drop", 32'(bus.full), 32'(0));
        check("bp_first_pwe", 32'(bus.packed_write_enable), 32'(1));
        check("bp_first_data", 32'(bus.packed_write_data), 32'h04030201);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("bp_second_pwe", 32'(bus.packed_write_enable), 32'(1));
        check("bp_second_data", 32'(bus.packed_write_data), 32'h08070605);

        // Mid-operation reset
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mrst_pending", 32'(bus.pending), 32'(0));
        check("mrst_pwe", 32'(bus.packed_write_enable), 32'(0));
        base = wr_count;
        for (int b = 0; b < 4; b++) step(1'b1, W'(8'h10 + b), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("mrst_data", 32'(bus.packed_write_data), 32'h13121110);
        check("mrst_mask", 32'(bus.packed_write_mask), 32'hF);
        check("mrst_pwe", 32'(bus.packed_write_enable), 32'(1));

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            pf = 1'($urandom_range(0, 1));
            we = !model_full(pf) && 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 99) < 5);
            step(we, W'($urandom_range(0, 255)), fl, pf, 1'b0);
        end
        for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        check("sb_drained", 32'(sb_data.size()), 32'(0));
        check("final_pending", 32'(bus.pending), 32'(0));
        check("writes_seen", 32'(wr_count > base + 1), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
